// File: rtl/disp_pkg.sv
// Shared types and helpers for the display arbiter: FSM state encoding,
// display data width and per-source data slice extraction.
package disp_pkg;

    localparam int DISP_W  = 4;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_e;

    // Sources are packed at 4 bits each; callers zero-extend to MAX_REQ slices.
    function automatic logic [DISP_W-1:0] disp_slice(
        input logic [DISP_W*MAX_REQ-1:0] data,
        input int unsigned               idx
    );
        return data[idx*DISP_W +: DISP_W];
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester/display bus of the display arbiter. The arbiter is the slave side;
// the requester pool plus display driver form the master side.
interface display_arbiter_if
    import disp_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [DISP_W*NREQ-1:0] data_in;
    logic [NREQ-1:0]        grant;
    logic [DISP_W-1:0]      data_out;
    logic [IW-1:0]          src;
    logic                   active;
    logic                   done;

    modport master (
        output req, data_in,
        input  grant, data_out, src, active, done
    );

    modport slave (
        input  req, data_in,
        output grant, data_out, src, active, done
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin after last_i by default,
// fixed lowest-index priority when DISP_ARB_PRIORITY_EN is defined.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
`ifndef DISP_ARB_PRIORITY_EN
    input  logic [IW-1:0]   last_i,
`endif
    output logic [IW-1:0]   win_o,
    output logic            any_o
);

`ifdef DISP_ARB_PRIORITY_EN
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_o = IW'(k);
            end
        end
    end
`else
    // Scan backwards so the earliest position after last_i overwrites the rest.
    always_comb begin
        int unsigned idx;
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_i) + k) % NREQ;
            if (req_i[idx]) begin
                win_o = IW'(idx);
                any_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/display_arbiter.sv
// Time-shares the seven-segment display among NREQ requesters with a fixed
// dwell window each. Define DISP_ARB_PRIORITY_EN for fixed-priority selection.
module display_arbiter
    import disp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    display_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [DISP_W-1:0] data_q, data_d;
    logic [IW-1:0]     src_q, src_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    logic [IW-1:0]     win;
    logic              any;
    logic [DISP_W*MAX_REQ-1:0] data_ext;

    assign data_ext = (DISP_W*MAX_REQ)'(bus.data_in);

`ifdef DISP_ARB_PRIORITY_EN
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (bus.req),
        .win_o (win),
        .any_o (any)
    );
`else
    logic [IW-1:0] last_q, last_d;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        data_d   = data_q;
        src_d    = src_q;
        active_d = active_q;
        done_d   = 1'b0;
`ifndef DISP_ARB_PRIORITY_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d  = NREQ'(1) << win;
                    src_d    = win;
                    data_d   = disp_slice(data_ext, win);
                    active_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = SHOW;
`ifndef DISP_ARB_PRIORITY_EN
                    last_d   = win;
`endif
                end
            end
            // Inputs are deliberately ignored here: the window is never cut short.
            SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    grant_d  = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            src_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifndef DISP_ARB_PRIORITY_EN
            last_q   <= IW'(NREQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            src_q    <= src_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifndef DISP_ARB_PRIORITY_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.data_out = data_q;
    assign bus.src      = src_q;
    assign bus.active   = active_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (NREQ=4, DWELL=4) with an expected-grant
// scoreboard; DISP_ARB_PRIORITY_EN switches the expected contention order.
module tb_display_arbiter;
    import disp_pkg::*;

    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    typedef struct {
        int         idx;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_arbiter_if #(.NREQ(NREQ)) bus ();

    display_arbiter #(.NREQ(NREQ), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slice(input int i, input logic [3:0] v);
        bus.data_in[4*i +: 4] = v;
    endtask

    // Waits (bounded) for a grant, then checks it against the scoreboard head.
    task automatic wait_grant(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant == '0 && n < 20);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty observed_grant=0x%0h", tag, bus.grant);
            cur = '{idx: 0, val: 4'h0};
            return;
        end
        cur = sb.pop_front();
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(4'b0001 << cur.idx));
        chk({tag, "_src"}, 32'(bus.src), 32'(cur.idx));
        chk({tag, "_data"}, 32'(bus.data_out), 32'(cur.val));
        chk({tag, "_active"}, 32'(bus.active), 32'd1);
    endtask

    // Counts the remaining grant cycles; returns on the DONE cycle.
    task automatic finish_window(input string tag);
        int hi;
        hi = 1;
        forever begin
            @(negedge clk);
            if (bus.grant == '0 || hi >= 20) break;
            hi++;
        end
        chk({tag, "_dwell"}, hi, DWELL);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_inactive"}, 32'(bus.active), 32'd0);
        chk({tag, "_hold_data"}, 32'(bus.data_out), 32'(cur.val));
        chk({tag, "_hold_src"}, 32'(bus.src), 32'(cur.idx));
        $display("[TB] %s: src=%0d data=%h dwell=%0d", tag, cur.idx, cur.val, hi);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req     = '0;
        bus.data_in = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: every output stays at its reset value.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({bus.grant, bus.data_out, bus.src, bus.active, bus.done}), 32'd0);
        end
        chk("idle_state", 32'(dut.state_q), 32'(IDLE));
        $display("[TB] idle: 20 cycles with no request");

        // Single request from source 2 carrying -3.
        set_slice(2, 4'b1101);
        bus.req = 4'b0100;
        sb.push_back('{idx: 2, val: 4'b1101});
        wait_grant("single", 1);
        bus.req = '0;
        finish_window("single");
        @(negedge clk);
        chk("single_done_pulse", 32'(bus.done), 32'd0);
        chk("single_released", 32'(bus.grant), 32'd0);
        repeat (3) @(negedge clk);
        chk("single_persist_data", 32'(bus.data_out), 32'hD);
        chk("single_persist_src", 32'(bus.src), 32'd2);

        // Full contention from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_slice(0, 4'h1);
        set_slice(1, 4'h7);
        set_slice(2, 4'h8);
        set_slice(3, 4'hE);
        bus.req = 4'b1111;
`ifdef DISP_ARB_PRIORITY_EN
        for (int k = 0; k < 5; k++) sb.push_back('{idx: 0, val: 4'h1});
`else
        sb.push_back('{idx: 0, val: 4'h1});
        sb.push_back('{idx: 1, val: 4'h7});
        sb.push_back('{idx: 2, val: 4'h8});
        sb.push_back('{idx: 3, val: 4'hE});
        sb.push_back('{idx: 0, val: 4'h1});
`endif
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("contend%0d", k), (k == 0) ? 1 : 2);
            if (k == 4) bus.req = '0;
            finish_window($sformatf("contend%0d", k));
        end

        // Source 1 drops its request and changes its value mid-window.
        @(negedge clk);
        set_slice(1, 4'h5);
        bus.req = 4'b0010;
        sb.push_back('{idx: 1, val: 4'h5});
        wait_grant("midchg", 1);
        bus.req = '0;
        set_slice(1, 4'hA);
        finish_window("midchg");

        // Reset on the second SHOW cycle aborts the window silently.
        @(negedge clk);
        set_slice(0, 4'h3);
        bus.req = 4'b0001;
        sb.push_back('{idx: 0, val: 4'h3});
        wait_grant("abort", 1);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'({bus.grant, bus.data_out, bus.src, bus.active, bus.done}), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({bus.grant, bus.done}), 32'd0);
        end
        $display("[TB] abort: reset mid-window, outputs cleared");

        set_slice(1, 4'h9);
        set_slice(3, 4'h2);
        bus.req = 4'b1010;
        sb.push_back('{idx: 1, val: 4'h9});
        wait_grant("postrst", 1);
        bus.req = '0;
        finish_window("postrst");

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
